memory_access_unit: RTL
=======================

# memory_access_unit

Pipeline MEM-stage responder that executes the memory-stage controls produced by the MEM control decode: `write_enable` and the 2-bit `address_control`. It owns the data memory and the input port, and it produces the value forwarded to write-back. Multi-cycle memory operations stall the upstream pipeline through a busy handshake. ALU and COPY INPUT operations complete in one cycle.

## Interface

- `DATA_W`, 16, data word width
- `ADDR_W`, 8, memory address width; depth = 2^ADDR_W words; address = `alu_result[ADDR_W-1:0]`
- `READ_LAT`, 2, busy cycles for a load (≥1)
- `WRITE_LAT`, 1, busy cycles for a store (≥1)
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high
- `valid_in`  in  1  instruction present in the MEM stage
- `instruction_in`  in  20  instruction word; carried alongside the result
- `write_enable`  in  1  store request from the MEM control decode
- `address_control`  in  2  00 = ALU pass-through, 01 = COPY INPUT, 10 = STORE, 11 = LOAD
- `alu_result`  in  DATA_W  address for STORE/LOAD; the result for pass-through
- `store_data`  in  DATA_W  write data for STORE
- `input_port`  in  DATA_W  external input for COPY INPUT
- `stall`  out  1  unit busy; upstream holds all inputs stable
- `valid_out`  out  1  `result_out` and `instruction_out` valid for one cycle
- `result_out`  out  DATA_W  value forwarded to write-back
- `instruction_out`  out  20  instruction associated with `result_out`

## Operation

- **FSM states:** IDLE, BUSY. `stall = (state == BUSY)`.
- **Acceptance:** an edge with `valid_in=1` and `stall=0`.
- **Pass-through (00) at acceptance:**
  - `result_out <= alu_result`, `instruction_out <= instruction_in`, `valid_out <= 1`.
  - State stays IDLE.
- **COPY INPUT (01) at acceptance:** same as pass-through, except `result_out <=` the sampled input port value.
- **STORE (10) or LOAD (11) at acceptance:**
  - Latch address, `store_data`, op and `instruction_in`.
  - Load counter with LAT−1, where LAT is `WRITE_LAT` or `READ_LAT`.
  - State → BUSY; `valid_out <= 0`.
- **BUSY, counter ≠ 0:** decrement the counter. `valid_out` stays 0.
- **BUSY, counter = 0:** the op completes on this edge.
  - STORE: `mem[addr] <= data`, `result_out <= 0`.
  - LOAD: `result_out <= mem[addr]`.
  - In both cases: `valid_out <= 1`, `instruction_out <=` latched instruction, state → IDLE.
- **`write_enable` consistency:** `write_enable` must equal (`address_control == 10`).
  - If `write_enable=1` with any other code, the op is treated as STORE.
  - If `write_enable=0` with code 10, the op is treated as pass-through and no write occurs.
- **Inputs during BUSY:** `valid_in` is ignored while BUSY. No second acceptance happens until the state returns to IDLE.
- **`valid_out` lifetime:** `valid_out` is a single-cycle pulse. It clears on the next edge unless another op completes on that edge.
- **Back-to-back acceptance:** a new acceptance may occur on the edge right after the IDLE return, so `valid_out` pulses back-to-back.
- **Memory contents:** not reset. Contents are undefined until written.
- **Address width:** address bits above `ADDR_W` are ignored, so addresses wrap modulo 2^ADDR_W.

## Timing

- **Reset values (asynchronous, immediate):** state = IDLE, `stall=0`, `valid_out=0`, `result_out=0`, `instruction_out=0`, counter = 0. Input sync flops are 0.
- **Reset mid-BUSY:** the pending store is dropped and the memory is unchanged. The pending load is dropped.
- **Latency, pass-through and COPY INPUT:** 1 edge from acceptance to `valid_out`.
- **Latency, STORE/LOAD:** LAT+1 edges from acceptance to `valid_out`. `stall` is high for exactly LAT cycles.
- **LOAD after STORE to the same address:** the load returns the stored data. The write completes before the load can be accepted.

## Configuration

- **`MEM_INPUT_SYNC_EN` defined:** `input_port` passes through a two-flop synchronizer before COPY INPUT samples it. The captured value is `input_port` as it was two edges before acceptance.
- **`MEM_INPUT_SYNC_EN` undefined:** COPY INPUT samples `input_port` directly at the acceptance edge.

## Test plan

- **Reset:** assert reset mid-cycle → all outputs 0 immediately; `stall=0`.
- **Pass-through:** `alu_result=0x1234`, code 00 → next cycle `valid_out=1`, `result_out=0x1234`, `stall` never asserted.
- **STORE then LOAD, defaults:**
  - STORE `0xBEEF` to address 0x05 → `stall` high 1 cycle; `valid_out` 2 edges after acceptance with `result_out=0`.
  - LOAD from 0x05 → `stall` high 2 cycles; `valid_out` 3 edges after acceptance with `result_out=0xBEEF`.
- **Address wrap:** STORE `0x00AA` to `alu_result=0x0105` → LOAD from 0x05 returns `0x00AA`.
- **COPY INPUT with macro:** `input_port=0x0042` held 3 cycles, then code 01 → `result_out=0x0042`. Change `input_port` 1 cycle before acceptance → the previous value is captured with the macro, the new value without it.
- **Reset during BUSY:** STORE `0x1111` to 0x07 with reset asserted while BUSY; then LOAD 0x07 after a prior write of `0x2222` → returns `0x2222`, no `valid_out` for the aborted store.

Source files
------------

// File: rtl/memory_access_unit_if.sv
`timescale 1ns/1ps
// memory_access_unit_if: request/response bundle between the pipeline and
// the MEM-stage responder. The pipeline side is the master (it drives the
// instruction and its memory-stage controls). The memory unit is the slave
// (it drives the stall back-pressure and the write-back result).
interface memory_access_unit_if #(
    parameter int DATA_W = 16
);
    logic              valid_in;
    logic [19:0]       instruction_in;
    logic              write_enable;
    logic [1:0]        address_control;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic              stall;
    logic              valid_out;
    logic [DATA_W-1:0] result_out;
    logic [19:0]       instruction_out;

    modport master (
        output valid_in,
        output instruction_in,
        output write_enable,
        output address_control,
        output alu_result,
        output store_data,
        input  stall,
        input  valid_out,
        input  result_out,
        input  instruction_out
    );

    modport slave (
        input  valid_in,
        input  instruction_in,
        input  write_enable,
        input  address_control,
        input  alu_result,
        input  store_data,
        output stall,
        output valid_out,
        output result_out,
        output instruction_out
    );
endinterface

// File: rtl/memory_access_unit.sv
`timescale 1ns/1ps
// memory_access_unit: MEM-stage responder. It executes ALU pass-through and
// COPY INPUT in a single edge, and runs STORE/LOAD against the local data
// memory over a fixed number of busy cycles while holding the pipeline with
// stall. The result and its instruction go to write-back as a one-cycle pulse.
//
// Optional feature: define MEM_INPUT_SYNC_EN to route input_port through a
// two-flop synchronizer before COPY INPUT samples it. Without the macro the
// port is sampled directly at the acceptance edge.
module memory_access_unit #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    input_port,
    memory_access_unit_if.slave  bus
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CNT_W-1:0] READ_CNT  = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WRITE_CNT = CNT_W'(WRITE_LAT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OP_PASS  = 2'b00,
        OP_COPY  = 2'b01,
        OP_STORE = 2'b10,
        OP_LOAD  = 2'b11
    } op_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [19:0]       pend_instr_q, pend_instr_d;
    logic              valid_out_q, valid_out_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [19:0]       instr_out_q, instr_out_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [DATA_W-1:0] copy_value;
    op_e               op_in;

    // Effective operation: write_enable is authoritative for stores, so a
    // raised write_enable forces STORE and code 10 without it is demoted to
    // pass-through.
    always_comb begin
        op_in = OP_PASS;
        if (bus.write_enable) begin
            op_in = OP_STORE;
        end else begin
            unique case (bus.address_control)
                2'b01:   op_in = OP_COPY;
                2'b11:   op_in = OP_LOAD;
                default: op_in = OP_PASS;
            endcase
        end
    end

`ifdef MEM_INPUT_SYNC_EN
    logic [DATA_W-1:0] sync1_q, sync1_d;
    logic [DATA_W-1:0] sync2_q, sync2_d;

    // Next values of the two synchronizer stages.
    always_comb begin
        sync1_d = input_port;
        sync2_d = sync1_q;
    end

    // Two-flop synchronizer on the external input; COPY INPUT sees the
    // port value from two edges earlier.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign copy_value = sync2_q;
`else
    assign copy_value = input_port;
`endif

    // Next-state logic: accept in IDLE, count down in BUSY, and complete the
    // pending memory operation when the counter has run out.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pend_instr_d = pend_instr_q;
        valid_out_d  = 1'b0;
        result_d     = result_q;
        instr_out_d  = instr_out_q;
        mem_we       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    unique case (op_in)
                        OP_PASS: begin
                            valid_out_d = 1'b1;
                            result_d    = bus.alu_result;
                            instr_out_d = bus.instruction_in;
                        end
                        OP_COPY: begin
                            valid_out_d = 1'b1;
                            result_d    = copy_value;
                            instr_out_d = bus.instruction_in;
                        end
                        default: begin
                            op_d         = op_in;
                            addr_d       = bus.alu_result[ADDR_W-1:0];
                            wdata_d      = bus.store_data;
                            pend_instr_d = bus.instruction_in;
                            cnt_d        = (op_in == OP_STORE) ? WRITE_CNT : READ_CNT;
                            state_d      = ST_BUSY;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    valid_out_d = 1'b1;
                    instr_out_d = pend_instr_q;
                    state_d     = ST_IDLE;
                    if (op_q == OP_STORE) begin
                        mem_we   = 1'b1;
                        result_d = '0;
                    end else begin
                        result_d = mem_q[addr_q];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state, pending operation and registered write-back outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= OP_PASS;
            addr_q       <= '0;
            wdata_q      <= '0;
            pend_instr_q <= '0;
            valid_out_q  <= 1'b0;
            result_q     <= '0;
            instr_out_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pend_instr_q <= pend_instr_d;
            valid_out_q  <= valid_out_d;
            result_q     <= result_d;
            instr_out_q  <= instr_out_d;
        end
    end

    // Data memory: not reset; a reset during BUSY returns the FSM to IDLE
    // asynchronously, so a pending store never reaches this write.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign bus.stall           = (state_q == ST_BUSY);
    assign bus.valid_out       = valid_out_q;
    assign bus.result_out      = result_q;
    assign bus.instruction_out = instr_out_q;

endmodule
